// File: rtl/uop_decode_pkg.sv
// Shared types for the micro-op decode stage.
// Fetched/decoded slot layouts and the opcode lookup.
package uop_decode_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 12;
  localparam int REG_W = 5;
  localparam int OPC_W = 7;

  typedef enum logic [2:0] {
    OC_ILLEGAL,
    OC_ALU,
    OC_ALUI,
    OC_LOAD,
    OC_STORE,
    OC_BRANCH,
    OC_UPPER,
    OC_JUMP
  } op_class_e;

  typedef enum logic {
    PAIR,
    SPLIT
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } fetched_instruction;

  typedef struct packed {
    logic             valid;
    op_class_e        op_class;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             writes_rd;
    logic [XLEN-1:0]  imm;
  } decoded_instruction;

  typedef struct packed {
    op_class_e op_class;
    logic      uses_rs1;
    logic      uses_rs2;
    logic      writes_rd;
  } op_info_t;

  function automatic op_info_t op_lookup(
    input logic [OPC_W-1:0] opc
  );
    op_info_t r;
    r.op_class  = OC_ILLEGAL;
    r.uses_rs1  = 1'b0;
    r.uses_rs2  = 1'b0;
    r.writes_rd = 1'b0;
    case (opc)
      7'h33: begin
        r.op_class  = OC_ALU;
        r.uses_rs1  = 1'b1;
        r.uses_rs2  = 1'b1;
        r.writes_rd = 1'b1;
      end
      7'h13: begin
        r.op_class  = OC_ALUI;
        r.uses_rs1  = 1'b1;
        r.writes_rd = 1'b1;
      end
      7'h03: begin
        r.op_class  = OC_LOAD;
        r.uses_rs1  = 1'b1;
        r.writes_rd = 1'b1;
      end
      7'h23: begin
        r.op_class = OC_STORE;
        r.uses_rs1 = 1'b1;
        r.uses_rs2 = 1'b1;
      end
      7'h63: begin
        r.op_class = OC_BRANCH;
        r.uses_rs1 = 1'b1;
        r.uses_rs2 = 1'b1;
      end
      7'h37: begin
        r.op_class  = OC_UPPER;
        r.writes_rd = 1'b1;
      end
      7'h6F: begin
        r.op_class  = OC_JUMP;
        r.writes_rd = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uop_decode_if.sv
// Instruction/decoded slot bundle between fetch, decode and rename.
// master drives fetched slots; slave is the decode stage.
interface uop_decode_if;
  import uop_decode_pkg::*;

  fetched_instruction instruction_1;
  fetched_instruction instruction_2;
  decoded_instruction decoded_1;
  decoded_instruction decoded_2;

  modport master (
    output instruction_1,
    output instruction_2,
    input  decoded_1,
    input  decoded_2
  );

  modport slave (
    input  instruction_1,
    input  instruction_2,
    output decoded_1,
    output decoded_2
  );
endinterface

// File: rtl/uop_field_decode.sv
// Combinational field extraction for one fetched slot.
module uop_field_decode
  import uop_decode_pkg::*;
(
  input  fetched_instruction i_inst,
  output decoded_instruction o_dec
);

  op_info_t w_info;

  always_comb begin
    w_info         = op_lookup(i_inst.opcode);
    o_dec.valid    = i_inst.valid;
    o_dec.op_class = w_info.op_class;
    o_dec.rd       = i_inst.rd;
    o_dec.rs1      = i_inst.rs1;
    o_dec.rs2      = i_inst.rs2;
    o_dec.uses_rs1 = w_info.uses_rs1;
    o_dec.uses_rs2 = w_info.uses_rs2;
    // x0 is never a real destination
    o_dec.writes_rd = w_info.writes_rd
                    && (i_inst.rd != '0);
    o_dec.imm = {{(XLEN-IMM_W){i_inst.imm[IMM_W-1]}},
                 i_inst.imm};
  end

endmodule

// File: rtl/uop_decode.sv
// Dual-slot micro-op decode stage with intra-bundle RAW split.
// Optional split counter under UOP_DECODE_STATS_EN.
module uop_decode
  import uop_decode_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic stalled,
  input  logic next_stalled,
  output logic valid,
  input  logic prev_valid,
  input  logic enabled,
  input  logic next_enabled,
  uop_decode_if.slave bus
`ifdef UOP_DECODE_STATS_EN
  ,
  output logic [31:0] split_count
`endif
);

  state_e r_state, w_state_nxt;
  logic   r_valid, w_valid_nxt;
  decoded_instruction r_dec1, w_dec1_nxt;
  decoded_instruction r_dec2, w_dec2_nxt;
  decoded_instruction r_held, w_held_nxt;
  decoded_instruction w_d1, w_d2;
  logic w_raw, w_hazard, w_split_go;

  uop_field_decode u_dec1 (
    .i_inst (bus.instruction_1),
    .o_dec  (w_d1)
  );

  uop_field_decode u_dec2 (
    .i_inst (bus.instruction_2),
    .o_dec  (w_d2)
  );

  always_comb begin
    w_raw = (w_d2.uses_rs1 && w_d1.rd == w_d2.rs1)
         || (w_d2.uses_rs2 && w_d1.rd == w_d2.rs2);
    w_hazard = w_d1.valid && w_d2.valid
            && w_d1.writes_rd && (w_d1.rd != '0)
            && w_raw;
    w_split_go = !clear && enabled
              && (r_state == PAIR)
              && w_hazard && prev_valid;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_dec1_nxt  = r_dec1;
    w_dec2_nxt  = r_dec2;
    w_held_nxt  = r_held;
    if (clear) begin
      w_state_nxt      = PAIR;
      w_valid_nxt      = 1'b0;
      w_dec1_nxt.valid = 1'b0;
      w_dec2_nxt.valid = 1'b0;
      w_held_nxt.valid = 1'b0;
    end else if (enabled) begin
      if (r_state == SPLIT) begin
        w_dec1_nxt       = r_held;
        w_dec2_nxt.valid = 1'b0;
        w_valid_nxt      = 1'b1;
        w_state_nxt      = PAIR;
      end else if (w_split_go) begin
        w_dec1_nxt       = w_d1;
        w_dec2_nxt.valid = 1'b0;
        w_held_nxt       = w_d2;
        w_valid_nxt      = 1'b1;
        w_state_nxt      = SPLIT;
      end else begin
        w_dec1_nxt  = w_d1;
        w_dec2_nxt  = w_d2;
        w_valid_nxt = prev_valid;
      end
    end else if (next_enabled) begin
      w_valid_nxt      = 1'b0;
      w_dec1_nxt.valid = 1'b0;
      w_dec2_nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PAIR;
      r_valid <= 1'b0;
      r_dec1  <= '0;
      r_dec2  <= '0;
      r_held  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_dec1  <= w_dec1_nxt;
      r_dec2  <= w_dec2_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign stalled = (prev_valid && next_stalled)
                || (r_state == SPLIT);
  assign valid         = r_valid;
  assign bus.decoded_1 = r_dec1;
  assign bus.decoded_2 = r_dec2;

`ifdef UOP_DECODE_STATS_EN
  logic [31:0] r_split_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_split_count <= '0;
    else if (w_split_go)
      r_split_count <= r_split_count + 32'd1;
  end

  assign split_count = r_split_count;
`endif

endmodule

// File: doc/uop_decode.md
Name: uop_decode

Overview:
- Pipeline stage directly downstream of micro-op fetch. Consumes the two fetched_instruction slots per cycle and produces two decoded_instruction slots for rename/issue.
- Field extraction: register indices, sign-extended immediate, operation class, write-enable.
- Detects a read-after-write dependency inside a bundle (slot 2 reads slot 1's destination). Splits such a bundle over two cycles, stalling upstream for one cycle.
- Uses the same stalled/valid/enabled/next_enabled/clear handshake as the neighbouring stages.

Parameters:
- XLEN, 32, width of decoded immediate/operand datapath
- IMM_W, 12, width of raw immediate field in fetched_instruction
- REG_W, 5, register index width; register 0 is hardwired zero

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous pipeline flush
- stalled  output  1  to upstream: hold current output
- next_stalled  input  1  downstream is stalled
- valid  output  1  decoded outputs hold a live bundle
- prev_valid  input  1  upstream fetched outputs are live
- enabled  input  1  this stage advances this cycle
- next_enabled  input  1  downstream stage advances this cycle
- instruction_1  input  fetched_instruction  older fetched slot
- instruction_2  input  fetched_instruction  younger fetched slot
- decoded_1  output  decoded_instruction  older decoded slot
- decoded_2  output  decoded_instruction  younger decoded slot
- split_count  output  32  only with UOP_DECODE_STATS_EN; bundles split so far

Behaviour:
- Reset (async, immediate):
  - state=PAIR, valid=0
  - decoded_1.valid=0, decoded_2.valid=0, held slot cleared
  - split_count=0
- stalled (combinational) = (prev_valid && next_stalled) || state==SPLIT.
- Decode is combinational from inputs and registered on enabled; latency 1 cycle.
- Per slot:
  - rd/rs1/rs2 copied.
  - imm sign-extended IMM_W->XLEN.
  - op_class and writes_rd looked up from opcode via package function.
  - writes_rd forced 0 when rd==0.
- Hazard (combinational), all of the following true:
  - instruction_1.valid && instruction_2.valid
  - writes_rd(i1) && i1.rd!=0
  - i1.rd==i2.rs1 (when i2 uses rs1) or i1.rd==i2.rs2 (when i2 uses rs2)
- Priority each cycle: clear > enabled > next_enabled.
- clear: state=PAIR, valid<=0, both slot valids<=0, held slot discarded. Same when clear arrives mid-SPLIT.
- State PAIR, enabled:
  - no hazard: decoded_1<=dec(i1), decoded_2<=dec(i2), valid<=prev_valid.
  - hazard && prev_valid: decoded_1<=dec(i1), decoded_2.valid<=0, held<=dec(i2), valid<=1, state<=SPLIT.
- State SPLIT, enabled:
  - decoded_1<=held, decoded_2.valid<=0, valid<=1, state<=PAIR.
  - Inputs ignored; upstream holds them because stalled=1.
- Not enabled, next_enabled: valid<=0, slot valids<=0, state unchanged.
- Neither enabled nor next_enabled: all registers hold.
- Program order is preserved: the held i2 is always emitted before any newer bundle.
- A bundle whose i1 is invalid and i2 is valid passes through unchanged; never split.

Optional Feature:
- Macro UOP_DECODE_STATS_EN.
- Defined:
  - split_count port exists; 32-bit counter increments on each PAIR->SPLIT transition.
  - Wraps 0xFFFFFFFF->0.
  - Not cleared by clear; cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package (defines.inc/instruction.sv):
  - decoded_instruction struct: valid, op_class, rd, rs1, rs2, uses_rs1, uses_rs2, writes_rd, imm[XLEN]
  - op_class enum
  - opcode->class/uses/writes function
  - REG_W/IMM_W constants
- One sub-module, uop_field_decode: purely combinational, one fetched_instruction -> one decoded_instruction. Instantiated twice.

Test Plan:
- i1 = add r3,r1,r2; i2 = add r4,r5,r6; enabled, prev_valid=1 -> next cycle valid=1, both slots valid, stalled=0.
- i1 writes r3, i2 reads rs2=r3 -> cycle1: decoded_1=i1, decoded_2.valid=0, stalled=1; cycle2: decoded_1=i2, stalled=0; split_count=1.
- i1 writes r0, i2 reads r0 -> no split; both slots valid in one cycle.
- imm=0x800 with IMM_W=12 -> decoded imm=0xFFFFF800; imm=0x7FF -> 0x000007FF.
- Hazard bundle enters SPLIT, then clear -> valid=0, state PAIR, held i2 never emitted, stalled=0 next cycle.
- next_stalled=1, prev_valid=1 while in PAIR -> stalled=1; async reset mid-SPLIT -> all valids 0 immediately, split_count=0.
